neuron_state_scheduler: RTL and testbench

//  Time-multiplexes N_NEURONS neurons through one core update pipeline (Q3.12, 4-cycle latency).

---
 rtl/neuron_pkg.sv | 32 +++
 rtl/spike_fifo.sv | 53 +++++
 rtl/neuron_state_scheduler.sv | 172 +++++++++++++++++
 tb/tb_neuron_state_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module : neuron_pkg
// Brief  : Shared Q3.12 widths, reset values, pipeline depth, spike threshold
//          and sequencer state encoding for the neuron state scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
package neuron_pkg;

    localparam int c_n_neurons = 64;
    localparam int c_w         = 16;
    localparam int c_core_lat  = 4;
    localparam int c_spk_depth = 8;

    localparam logic [15:0] c_spike_th = 16'h0800;
    localparam logic [15:0] c_v_reset  = 16'hECE1;
    localparam logic [15:0] c_w_reset  = 16'hF600;

    localparam int          c_st_w    = 3;
    localparam logic [2:0]  c_st_init  = 3'd0;
    localparam logic [2:0]  c_st_idle  = 3'd1;
    localparam logic [2:0]  c_st_issue = 3'd2;
    localparam logic [2:0]  c_st_drain = 3'd3;
    localparam logic [2:0]  c_st_done  = 3'd4;

    // Index width never collapses to zero, even for a single neuron.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
// Module : spike_fifo
// Brief  : Synchronous first-word-fall-through FIFO for spiking neuron IDs;
//          a push into a full FIFO is accepted when a pop happens that cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 6
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_push,
    input  wire logic [DW-1:0] i_push_data,
    input  wire logic          i_pop,
    output logic      [DW-1:0] o_head,
    output logic               o_empty,
    output logic               o_full
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [c_aw:0] r_wr_ptr;
    logic [c_aw:0] r_rd_ptr;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_head    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // When full, the slot being written is the one popped this same cycle.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/neuron_state_scheduler.sv
`default_nettype none
// ============================================================================
// Module : neuron_state_scheduler
// Brief  : Sweeps per-neuron v/w state through a shared fixed-latency update
//          core, writes results back, and queues upward threshold crossings.
// Rev    : 1.0 - initial release
// ============================================================================
module neuron_state_scheduler
    import neuron_pkg::*;
#(
    parameter int           N_NEURONS = c_n_neurons,
    parameter int           W         = c_w,
    parameter int           CORE_LAT  = c_core_lat,
    parameter logic [W-1:0] SPIKE_TH  = c_spike_th,
    parameter logic [W-1:0] V_RESET   = c_v_reset,
    parameter logic [W-1:0] W_RESET   = c_w_reset,
    parameter int           SPK_DEPTH = c_spk_depth,
    localparam int          NW        = idx_width(N_NEURONS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          step_start,
    output logic               busy,
    output logic               done,
    output logic [15:0]        step_count,
    output logic [NW-1:0]      i_addr,
    input  wire logic [W-1:0]  i_data,
    output logic [W-1:0]       core_v,
    output logic [W-1:0]       core_w,
    output logic [W-1:0]       core_i,
    input  wire logic [W-1:0]  core_v_out,
    input  wire logic [W-1:0]  core_w_out,
    output logic               spk_valid,
    output logic [NW-1:0]      spk_id,
    input  wire logic          spk_ready,
    output logic               spk_overflow
);

    localparam logic [NW-1:0] c_last = NW'(N_NEURONS - 1);

    logic [c_st_w-1:0] r_state;
    logic [NW-1:0]     r_idx;
    logic [W-1:0]      r_vmem [N_NEURONS];
    logic [W-1:0]      r_wmem [N_NEURONS];
    logic [W-1:0]      r_rd_v;
    logic [W-1:0]      r_rd_w;
    logic [W-1:0]      r_core_i;
    logic [15:0]       r_step_count;
    logic              r_ovf;

    // Writeback tracker: stage j holds the issue from j+1 cycles ago.
    logic [CORE_LAT:0] r_pv;
    logic [NW-1:0]     r_pidx [CORE_LAT+1];
    logic [W-1:0]      r_pold [1:CORE_LAT];

    logic              w_issue;
    logic              w_wb;
    logic [NW-1:0]     w_wb_idx;
    logic              w_spike;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [NW-1:0]     w_head;

    assign w_issue  = (r_state == c_st_issue);
    assign w_wb     = r_pv[CORE_LAT];
    assign w_wb_idx = r_pidx[CORE_LAT];
    assign w_spike  = w_wb &&
                      ($signed(r_pold[CORE_LAT]) < $signed(SPIKE_TH)) &&
                      ($signed(core_v_out) >= $signed(SPIKE_TH));
    assign w_pop    = spk_valid && spk_ready;

    assign busy         = (r_state != c_st_idle);
    assign done         = (r_state == c_st_done);
    assign step_count   = r_step_count;
    assign i_addr       = r_idx;
    assign core_v       = r_rd_v;
    assign core_w       = r_rd_w;
    assign core_i       = r_pv[0] ? i_data : r_core_i;
    assign spk_valid    = !w_empty;
    assign spk_id       = w_empty ? '0 : w_head;
    assign spk_overflow = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_init;
            r_idx        <= '0;
            r_step_count <= '0;
            r_rd_v       <= '0;
            r_rd_w       <= '0;
            r_core_i     <= '0;
            r_pv         <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_pv <= {r_pv[CORE_LAT-1:0], w_issue};
            if (w_issue) begin
                r_rd_v <= r_vmem[r_idx];
                r_rd_w <= r_wmem[r_idx];
            end
            if (r_pv[0]) r_core_i <= i_data;
            if (w_spike && w_full && !w_pop) r_ovf <= 1'b1;

            case (r_state)
                c_st_init: begin
                    r_idx <= r_idx + NW'(1);
                    if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= c_st_idle;
                    end
                end
                c_st_idle: begin
                    if (step_start) r_state <= c_st_issue;
                end
                c_st_issue: begin
                    r_idx <= r_idx + NW'(1);
                    if (r_idx == c_last) begin
                        r_idx   <= '0;
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_wb && (w_wb_idx == c_last)) r_state <= c_st_done;
                end
                c_st_done: begin
                    r_step_count <= r_step_count + 16'd1;
                    r_state      <= c_st_idle;
                end
                default: r_state <= c_st_init;
            endcase
        end
    end

    // Index and old-v travel alongside the valid bits; only the valids need reset.
    always_ff @(posedge clk) begin
        r_pidx[0] <= r_idx;
        for (int j = 1; j <= CORE_LAT; j++) begin
            r_pidx[j] <= r_pidx[j-1];
        end
        r_pold[1] <= r_rd_v;
        for (int j = 2; j <= CORE_LAT; j++) begin
            r_pold[j] <= r_pold[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == c_st_init) begin
                r_vmem[r_idx] <= V_RESET;
                r_wmem[r_idx] <= W_RESET;
            end else if (w_wb) begin
                r_vmem[w_wb_idx] <= core_v_out;
                r_wmem[w_wb_idx] <= core_w_out;
            end
        end
    end

    spike_fifo #(
        .DEPTH (SPK_DEPTH),
        .DW    (NW)
    ) u_spike_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_spike),
        .i_push_data (w_wb_idx),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_neuron_state_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_neuron_state_scheduler
// Brief  : Two scheduler instances (4 and 16 neurons) with +0x0400 core stubs,
//          checked against a per-sweep arithmetic model of neuron state.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_neuron_state_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic step_start = 1'b0;
    logic spk_ready = 1'b0;
    logic sel = 1'b0;

    logic        busy4, done4, spk_valid4, spk_ovf4;
    logic [15:0] step_count4, core_v4, core_w4, core_i4, i_data4, core_v_out4, core_w_out4;
    logic [1:0]  i_addr4, spk_id4;
    logic        busy16, done16, spk_valid16, spk_ovf16;
    logic [15:0] step_count16, core_v16, core_w16, core_i16, i_data16, core_v_out16, core_w_out16;
    logic [3:0]  i_addr16, spk_id16;
    logic        ss4, ss16, rdy4, rdy16;

    assign ss4   = step_start & ~sel;
    assign ss16  = step_start & sel;
    assign rdy4  = spk_ready & ~sel;
    assign rdy16 = spk_ready & sel;

    neuron_state_scheduler #(.N_NEURONS(4)) u_dut4 (
        .clk(clk), .rst(rst), .step_start(ss4), .busy(busy4), .done(done4),
        .step_count(step_count4), .i_addr(i_addr4), .i_data(i_data4),
        .core_v(core_v4), .core_w(core_w4), .core_i(core_i4),
        .core_v_out(core_v_out4), .core_w_out(core_w_out4),
        .spk_valid(spk_valid4), .spk_id(spk_id4), .spk_ready(rdy4),
        .spk_overflow(spk_ovf4)
    );

    neuron_state_scheduler #(.N_NEURONS(16)) u_dut16 (
        .clk(clk), .rst(rst), .step_start(ss16), .busy(busy16), .done(done16),
        .step_count(step_count16), .i_addr(i_addr16), .i_data(i_data16),
        .core_v(core_v16), .core_w(core_w16), .core_i(core_i16),
        .core_v_out(core_v_out16), .core_w_out(core_w_out16),
        .spk_valid(spk_valid16), .spk_id(spk_id16), .spk_ready(rdy16),
        .spk_overflow(spk_ovf16)
    );

    // Core stubs (4-cycle delay, v += 0x0400) and registered current memory
    logic [15:0] cur_mem [16];
    logic [15:0] p4v [4], p4w [4], p16v [4], p16w [4];
    always @(posedge clk) begin
        p4v[0]  <= core_v4;  p4w[0]  <= core_w4;
        p16v[0] <= core_v16; p16w[0] <= core_w16;
        for (int j = 1; j < 4; j++) begin
            p4v[j]  <= p4v[j-1];  p4w[j]  <= p4w[j-1];
            p16v[j] <= p16v[j-1]; p16w[j] <= p16w[j-1];
        end
        i_data4  <= cur_mem[i_addr4];
        i_data16 <= cur_mem[i_addr16];
    end
    assign core_v_out4  = p4v[3] + 16'h0400;
    assign core_w_out4  = p4w[3];
    assign core_v_out16 = p16v[3] + 16'h0400;
    assign core_w_out16 = p16w[3];

    // Selected-instance view
    logic        obs_busy, obs_done, obs_valid, obs_ovf;
    logic [15:0] obs_count, obs_v, obs_w, obs_i;
    int          obs_addr, obs_id;
    always_comb begin
        obs_busy  = sel ? busy16 : busy4;
        obs_done  = sel ? done16 : done4;
        obs_valid = sel ? spk_valid16 : spk_valid4;
        obs_ovf   = sel ? spk_ovf16 : spk_ovf4;
        obs_count = sel ? step_count16 : step_count4;
        obs_v     = sel ? core_v16 : core_v4;
        obs_w     = sel ? core_w16 : core_w4;
        obs_i     = sel ? core_i16 : core_i4;
        obs_addr  = sel ? int'(i_addr16) : int'(i_addr4);
        obs_id    = sel ? int'(spk_id16) : int'(spk_id4);
    end

    // Reference model: neuron state per instance, spike queue, counters
    logic [15:0] mv [2][16];
    logic [15:0] mw [2][16];
    int          mcount [2];
    int          mq [2][8];
    int          mhead [2];
    int          mcnt [2];
    bit          movf [2];
    int          npop;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                mv[s][k] = 16'hECE1;
                mw[s][k] = 16'hF600;
            end
            mcount[s] = 0; mhead[s] = 0; mcnt[s] = 0; movf[s] = 1'b0;
        end
    endtask

    task automatic model_push(input int s, input int id);
        if (mcnt[s] == 8) movf[s] = 1'b1;
        else begin
            mq[s][(mhead[s] + mcnt[s]) % 8] = id;
            mcnt[s]++;
        end
    endtask

    // Compares the FIFO head this cycle, then drives ready and retires a pop.
    task automatic fifo_cycle(input int s, input bit rdy);
        n_checks++;
        if (obs_valid !== (mcnt[s] != 0))
            $display("FAIL spk_valid: got %0b expected %0b", obs_valid, mcnt[s] != 0);
        else n_pass++;
        if (mcnt[s] != 0) begin
            n_checks++;
            if (obs_id !== mq[s][mhead[s]])
                $display("FAIL spk_id: got %0d expected %0d", obs_id, mq[s][mhead[s]]);
            else n_pass++;
        end
        if (rdy && obs_valid) npop++;
        spk_ready = rdy;
        if (rdy && mcnt[s] != 0) begin
            mhead[s] = (mhead[s] + 1) % 8;
            mcnt[s]--;
        end
    endtask

    task automatic run_sweep(input int s, input bit hold, input int pct, input int rfrom);
        int n;
        logic [15:0] old_v, new_v;
        n = (s != 0) ? 16 : 4;
        sel = (s != 0);
        n_checks++;
        if (obs_busy !== 1'b0) $display("FAIL idle_before_sweep: busy got %0b expected 0", obs_busy);
        else n_pass++;
        for (int k = 0; k < 16; k++) cur_mem[k] = 16'($urandom);
        step_start = 1'b1;
        tick();
        if (!hold) step_start = 1'b0;
        for (int cyc = 1; cyc <= n + 8; cyc++) begin
            if (cyc <= n) begin
                n_checks++;
                if (obs_addr !== cyc - 1 || obs_busy !== 1'b1)
                    $display("FAIL issue_addr c%0d: got addr %0d busy %0b expected addr %0d busy 1",
                             cyc, obs_addr, obs_busy, cyc - 1);
                else n_pass++;
            end
            if (cyc >= 2 && cyc <= n + 1) begin
                n_checks++;
                if (obs_v !== mv[s][cyc-2] || obs_w !== mw[s][cyc-2] || obs_i !== cur_mem[cyc-2])
                    $display("FAIL core_in k%0d: got v %h w %h i %h expected v %h w %h i %h", cyc - 2,
                             obs_v, obs_w, obs_i, mv[s][cyc-2], mw[s][cyc-2], cur_mem[cyc-2]);
                else n_pass++;
            end
            n_checks++;
            if (obs_done !== (cyc == n + 6))
                $display("FAIL done c%0d: got %0b expected %0b", cyc, obs_done, cyc == n + 6);
            else n_pass++;
            if (cyc == n + 7) begin
                n_checks++;
                if (obs_count !== 16'(mcount[s]))
                    $display("FAIL step_count: got %0d expected %0d", obs_count, mcount[s]);
                else n_pass++;
            end
            fifo_cycle(s, (cyc >= rfrom) && ($urandom_range(99) < pct));
            if (cyc >= 6 && cyc <= n + 5) begin
                old_v = mv[s][cyc-6];
                new_v = old_v + 16'h0400;
                if ($signed(old_v) < $signed(16'sh0800) && $signed(new_v) >= $signed(16'sh0800))
                    model_push(s, cyc - 6);
                mv[s][cyc-6] = new_v;
            end
            if (cyc == n + 6) begin
                mcount[s]++;
                step_start = 1'b0;
            end
            tick();
        end
        spk_ready = 1'b0;
        n_checks++;
        if (obs_ovf !== movf[s] || obs_busy !== 1'b0)
            $display("FAIL sweep_end: got ovf %0b busy %0b expected ovf %0b busy 0",
                     obs_ovf, obs_busy, movf[s]);
        else n_pass++;
    endtask

    task automatic drain(input int s, input int exp_pops);
        sel = (s != 0);
        for (int c = 0; c < 20 && mcnt[s] != 0; c++) begin
            fifo_cycle(s, 1'b1);
            tick();
        end
        spk_ready = 1'b0;
        n_checks++;
        if (obs_valid !== 1'b0 || npop !== exp_pops)
            $display("FAIL drain: got valid %0b pops %0d expected valid 0 pops %0d",
                     obs_valid, npop, exp_pops);
        else n_pass++;
    endtask

    task automatic wait_init(input int exp4, input int exp16);
        int b4, b16;
        b4 = -1; b16 = -1;
        for (int c = 0; c < 40; c++) begin
            if (b4 < 0 && busy4 === 1'b0) b4 = c;
            if (b16 < 0 && busy16 === 1'b0) b16 = c;
            tick();
        end
        n_checks++;
        if (b4 !== exp4 || b16 !== exp16)
            $display("FAIL init_len: got %0d/%0d busy cycles expected %0d/%0d", b4, b16, exp4, exp16);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({done4, spk_valid4, spk_ovf4, step_count4, core_v4, core_w4, i_addr4} !== '0 || busy4 !== 1'b1)
            $display("FAIL reset4: got done %0b valid %0b ovf %0b cnt %0d v %h w %h addr %0d busy %0b expected zeros busy 1",
                     done4, spk_valid4, spk_ovf4, step_count4, core_v4, core_w4, i_addr4, busy4);
        else n_pass++;
        n_checks++;
        if ({done16, spk_valid16, spk_ovf16, step_count16, core_v16, i_addr16} !== '0 || busy16 !== 1'b1)
            $display("FAIL reset16: got done %0b valid %0b ovf %0b cnt %0d v %h addr %0d busy %0b expected zeros busy 1",
                     done16, spk_valid16, spk_ovf16, step_count16, core_v16, i_addr16, busy16);
        else n_pass++;
        model_reset();
        rst = 1'b0;
        wait_init(4, 16);
    endtask

    task automatic test_first_sweep();
        npop = 0;
        run_sweep(0, 1'b0, 50, 0);
    endtask

    task automatic test_crossing();
        npop = 0;
        for (int i = 0; i < 8; i++) run_sweep(0, 1'b0, 50, 0);
        drain(0, 4);
    endtask

    task automatic test_back_to_back();
        run_sweep(0, 1'b1, 100, 0);
        tick(); tick();
        n_checks++;
        if (busy4 !== 1'b0 || step_count4 !== 16'(mcount[0]))
            $display("FAIL held_start: got busy %0b cnt %0d expected busy 0 cnt %0d",
                     busy4, step_count4, mcount[0]);
        else n_pass++;
    endtask

    task automatic test_overflow();
        npop = 0;
        for (int i = 0; i < 7; i++) run_sweep(1, 1'b0, 0, 0);
        n_checks++;
        if (spk_ovf16 !== 1'b1) $display("FAIL overflow_set: got %0b expected 1", spk_ovf16);
        else n_pass++;
        drain(1, 8);
    endtask

    task automatic test_rst_mid_issue();
        sel = 1'b0;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick(); tick();
        n_checks++;
        if (i_addr4 !== 2'd2) $display("FAIL mid_issue_addr: got %0d expected 2", i_addr4);
        else n_pass++;
        rst = 1'b1;
        tick(); tick();
        model_reset();
        rst = 1'b0;
        wait_init(4, 16);
        n_checks++;
        if (spk_ovf16 !== 1'b0 || spk_valid16 !== 1'b0 || step_count4 !== 16'd0)
            $display("FAIL rst_clears: got ovf %0b valid %0b cnt %0d expected 0 0 0",
                     spk_ovf16, spk_valid16, step_count4);
        else n_pass++;
        npop = 0;
        run_sweep(0, 1'b0, 100, 0);
        drain(0, 0);
    endtask

    task automatic test_full_push_pop();
        npop = 0;
        for (int i = 0; i < 6; i++) run_sweep(1, 1'b0, 0, 0);
        run_sweep(1, 1'b0, 100, 14);
        n_checks++;
        if (spk_ovf16 !== 1'b0) $display("FAIL full_push_pop_ovf: got %0b expected 0", spk_ovf16);
        else n_pass++;
        drain(1, 16);
    endtask

    initial begin
        test_reset();
        test_first_sweep();
        test_crossing();
        test_back_to_back();
        test_overflow();
        test_rst_mid_issue();
        test_full_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
